lowp_decim: RTL
===============

LOWP_DECIM -- requirements
Module: lowp_decim

Interface
REQ-001 Parameter W, default 28, sample width in bits (signed, two's complement).
REQ-002 Parameter MAXLOG, default 8, maximum decimation exponent; the accumulator SHALL be W+MAXLOG bits signed.
REQ-003 clock_in  input  1  single clock; all state SHALL change only on the rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  sample strobe; signal_in is valid only in cycles where enable=1.
REQ-006 signal_in  input  W  signed filtered sample from the low-pass stage.
REQ-007 decim_log2  input  4  decimation exponent k; the block averages 2^k samples; values above MAXLOG SHALL be treated as MAXLOG.
REQ-008 clear  input  1  synchronous active-high soft clear.
REQ-009 out_data  output  W  signed decimated sample at the FIFO head.
REQ-010 out_valid  output  1  out_data holds a valid sample.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 overrun  output  1  sticky flag: a result was dropped.
REQ-013 drop_count  output  16  count of dropped results, saturating.

Function
REQ-014 Cycles with enable=0 SHALL leave the accumulator, sample counter and k latch unchanged.
REQ-015 k SHALL be latched from decim_log2 on the first enable strobe of each block (sample counter = 0) and held for the whole block; mid-block changes to decim_log2 SHALL take effect at the next block.
REQ-016 Each strobe SHALL add sign-extended signal_in to the accumulator and increment the sample counter.
REQ-017 On the strobe that completes 2^k samples, result = (acc + signal_in) >>> k (arithmetic shift, truncation toward minus infinity, low W bits); the accumulator and counter SHALL return to 0 in the same edge.
REQ-018 For k=0 every strobe SHALL produce one result equal to signal_in.
REQ-019 Results SHALL enter a 2-entry FIFO with states EMPTY, ONE, TWO; out_valid=1 in ONE and TWO; out_data = oldest entry.
REQ-020 Pop SHALL occur on any edge where out_valid=1 and out_ready=1.
REQ-021 Latency: with the FIFO EMPTY, out_valid SHALL rise and out_data SHALL show the result on the edge that follows the final strobe of the block (one cycle).
REQ-022 Push in EMPTY -> ONE; push in ONE -> TWO; push plus pop in ONE -> stays ONE, new data at head; push plus pop in TWO -> stays TWO, order preserved; pop alone TWO -> ONE -> EMPTY.
REQ-023 Push in TWO without pop SHALL drop the new result, keep both stored entries, set overrun, and increment drop_count, saturating at 0xFFFF.
REQ-024 out_data and stored entries SHALL NOT change while out_valid=1 and out_ready=0, except as allowed by REQ-022 for the non-head entry.
REQ-025 clear=1 SHALL zero the accumulator, counter, k latch, overrun and drop_count and flush the FIFO to EMPTY; a strobe in the same cycle as clear SHALL be discarded.

Reset
REQ-026 With reset_n=0 at an edge, the following SHALL all be 0 on the next cycle: accumulator, sample counter, k latch, FIFO state (EMPTY), out_data, out_valid, overrun, drop_count.
REQ-027 reset_n SHALL take priority over clear, enable and out_ready; reset mid-block SHALL discard the partial accumulation.

Verification
REQ-028 k=2, out_ready=1, strobes with values 4,8,12,16 on consecutive cycles -> out_data=10 with out_valid=1 for exactly one cycle, starting one cycle after the 16 strobe.
REQ-029 k=1, strobes -3,-4 -> out_data=-4 (-7>>>1); k=3, eight strobes of -1 -> out_data=-1.
REQ-030 k=0, out_ready=0, strobes 1,2,3 -> FIFO TWO holding 1,2; overrun=1, drop_count=1; then out_ready=1 -> out_data 1 then 2 on consecutive cycles, then out_valid=0.
REQ-031 k=3, five strobes of 100, reset_n=0 for one cycle, then eight strobes of 7 -> exactly one result, value 7; no value containing 100 appears.
REQ-032 k=2 latched; decim_log2 changed to 0 after the second strobe; strobes 1,1,1,1,9 -> outputs 1 then 9.
REQ-033 k=8, 256 strobes of -2^27 with gaps of enable=0 interleaved -> out_data=-2^27, no wrap; then 70000 forced drops -> drop_count=0xFFFF.

Source files
------------

// File: rtl/lowp_decim_if.sv
// Sample-in / decimated-result-out bundle between the low-pass stage, the decimator and its consumer.
// The master side drives strobes, control and out_ready; the slave (decimator) returns results and drop status.
interface lowp_decim_if #(
  parameter int W = 28
);
  logic                enable;
  logic signed [W-1:0] signal_in;
  logic [3:0]          decim_log2;
  logic                clear;
  logic signed [W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                overrun;
  logic [15:0]         drop_count;

  modport master (
    output enable, signal_in, decim_log2, clear, out_ready,
    input  out_data, out_valid, overrun, drop_count
  );

  modport slave (
    input  enable, signal_in, decim_log2, clear, out_ready,
    output out_data, out_valid, overrun, drop_count
  );
endinterface

// File: rtl/lowp_decim.sv
// Block-average decimator: sums 2^k strobed samples, shifts right by k, and queues results in a 2-entry FIFO.
// Result is visible one cycle after the block's last strobe; a result arriving with the FIFO full is dropped and counted.
module lowp_decim #(
  parameter int W      = 28,
  parameter int MAXLOG = 8
) (
  input logic        clock_in,
  input logic        reset_n,
  lowp_decim_if.slave io
);

  localparam int AW = W + MAXLOG;
  localparam int CW = MAXLOG;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_st_e;

  fifo_st_e             st_q, st_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           k_q, k_d;
  logic signed [W-1:0]  head_q, head_d;
  logic signed [W-1:0]  tail_q, tail_d;
  logic                 ovr_q, ovr_d;
  logic [15:0]          drop_q, drop_d;

  logic [3:0]           k_clamp;
  logic [3:0]           k_use;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shifted;
  logic signed [W-1:0]  result;
  logic [CW-1:0]        term_cnt;
  logic                 last;
  logic                 push;
  logic                 pop;

  always_comb begin
    k_clamp  = (io.decim_log2 > MAXLOG[3:0]) ? MAXLOG[3:0] : io.decim_log2;
    // k is only sampled from the input on the first strobe of a block
    k_use    = (cnt_q == '0) ? k_clamp : k_q;
    sum      = acc_q + {{MAXLOG{io.signal_in[W-1]}}, io.signal_in};
    shifted  = sum >>> k_use;
    result   = shifted[W-1:0];
    // Wraps to all-ones when k == MAXLOG, which is exactly the last count of a full block
    term_cnt = (CW'(1) << k_use) - CW'(1);
    last     = (cnt_q == term_cnt);
    push     = io.enable && last;
    pop      = (st_q != EMPTY) && io.out_ready;
  end

  always_comb begin
    st_d   = st_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    k_d    = k_q;
    head_d = head_q;
    tail_d = tail_q;
    ovr_d  = ovr_q;
    drop_d = drop_q;

    if (io.clear) begin
      st_d   = EMPTY;
      acc_d  = '0;
      cnt_d  = '0;
      k_d    = '0;
      head_d = '0;
      tail_d = '0;
      ovr_d  = 1'b0;
      drop_d = '0;
    end else begin
      if (io.enable) begin
        k_d = k_use;
        if (last) begin
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CW'(1);
        end
      end

      unique case (st_q)
        EMPTY: begin
          if (push) begin
            head_d = result;
            st_d   = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = result;
          end else if (push) begin
            tail_d = result;
            st_d   = TWO;
          end else if (pop) begin
            st_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_d = tail_q;
            if (push) tail_d = result;
            else      st_d   = ONE;
          end else if (push) begin
            ovr_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end
        end
        default: st_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      st_q   <= EMPTY;
      acc_q  <= '0;
      cnt_q  <= '0;
      k_q    <= '0;
      head_q <= '0;
      tail_q <= '0;
      ovr_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      st_q   <= st_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      k_q    <= k_d;
      head_q <= head_d;
      tail_q <= tail_d;
      ovr_q  <= ovr_d;
      drop_q <= drop_d;
    end
  end

  assign io.out_data   = head_q;
  assign io.out_valid  = (st_q != EMPTY);
  assign io.overrun    = ovr_q;
  assign io.drop_count = drop_q;

endmodule
